mem_dump_seq: RTL and testbench

Parametrised memory-dump address sequencer for the 16-bit RISC processor debug path. It generalises the free-running dump counter: it issues a bounded, stepped run of memory addresses starting at a programmable base. Consumption is flow-controlled by a valid/ready handshake to the memory read port. It supports one-shot and continuous modes, abort, and pass counting.

---
 rtl/mem_dump_seq.sv | 99 +++++++++
 tb/tb_mem_dump_seq.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/mem_dump_seq.sv
// Memory-dump address sequencer: issues a bounded, stepped run of addresses from a
// programmable base over a valid/ready handshake, in one-shot or continuous mode.
module mem_dump_seq #(
  parameter int ADDR_W = 16,
  parameter int STEP   = 1,
  parameter int PASS_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              abort,
  input  logic              continuous,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W-1:0] length,
  output logic [ADDR_W-1:0] addr,
  output logic              addr_valid,
  input  logic              addr_ready,
  output logic [ADDR_W-1:0] index,
  output logic              busy,
  output logic              done,
  output logic [PASS_W-1:0] pass_cnt
);

  localparam logic [ADDR_W-1:0] STEP_INC = ADDR_W'(STEP);

  typedef enum logic [1:0] {IDLE, RUN, DONE} stateT;

  stateT             state;
  logic [ADDR_W-1:0] baseLatch;
  logic [ADDR_W-1:0] lastIndex;
  logic              contMode;

  // Abort always wins over a same-cycle transfer or start; the last-word
  // index is precomputed at start so the per-word compare stays simple.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      baseLatch  <= '0;
      lastIndex  <= '0;
      contMode   <= 1'b0;
      addr       <= '0;
      addr_valid <= 1'b0;
      index      <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      pass_cnt   <= '0;
    end else begin
      case (state)
        RUN: begin
          if (abort) begin
            state      <= IDLE;
            addr_valid <= 1'b0;
            busy       <= 1'b0;
          end else if (addr_ready) begin
            if (index == lastIndex) begin
              pass_cnt <= pass_cnt + PASS_W'(1);
              if (contMode) begin
                addr  <= baseLatch;
                index <= '0;
              end else begin
                state      <= DONE;
                addr_valid <= 1'b0;
                busy       <= 1'b0;
                done       <= 1'b1;
              end
            end else begin
              addr  <= addr + STEP_INC;
              index <= index + ADDR_W'(1);
            end
          end
        end
        default: begin
          done <= 1'b0;
          if (abort) begin
            state <= IDLE;
          end else if (start) begin
            pass_cnt <= '0;
            if (length != '0) begin
              baseLatch  <= base_addr;
              lastIndex  <= length - ADDR_W'(1);
              contMode   <= continuous;
              addr       <= base_addr;
              index      <= '0;
              addr_valid <= 1'b1;
              busy       <= 1'b1;
              state      <= RUN;
            end else begin
              done  <= 1'b1;
              state <= DONE;
            end
          end else begin
            state <= IDLE;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_dump_seq.sv
// Scoreboard bench for mem_dump_seq: expected addresses are queued per run and popped
// by a monitor on every accepted transfer; STEP=1 and STEP=2 instances share inputs.
module tb_mem_dump_seq;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start1 = 1'b0;
  logic        start2 = 1'b0;
  logic        abort = 1'b0;
  logic        continuous = 1'b0;
  logic [15:0] baseAddr = '0;
  logic [15:0] length = '0;
  logic        addrReady = 1'b0;

  logic [15:0] addr1, index1, addr2, index2;
  logic        valid1, busy1, done1, valid2, busy2, done2;
  logic [7:0]  pass1, pass2;

  logic [15:0] q1[$];
  logic [15:0] q2[$];
  int nCompared = 0;
  int nMismatch = 0;
  int xfer1 = 0, xfer2 = 0;
  int doneCount1 = 0, doneCount2 = 0;

  always #5 clk = ~clk;

  mem_dump_seq #(.ADDR_W(16), .STEP(1), .PASS_W(8)) dut1 (
    .clk(clk), .reset(reset), .start(start1), .abort(abort), .continuous(continuous),
    .base_addr(baseAddr), .length(length), .addr(addr1), .addr_valid(valid1),
    .addr_ready(addrReady), .index(index1), .busy(busy1), .done(done1), .pass_cnt(pass1)
  );

  mem_dump_seq #(.ADDR_W(16), .STEP(2), .PASS_W(8)) dut2 (
    .clk(clk), .reset(reset), .start(start2), .abort(abort), .continuous(continuous),
    .base_addr(baseAddr), .length(length), .addr(addr2), .addr_valid(valid2),
    .addr_ready(addrReady), .index(index2), .busy(busy2), .done(done2), .pass_cnt(pass2)
  );

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    nCompared++;
    if (actual !== expected) begin
      nMismatch++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input bit useDut2, input logic [15:0] b,
                               input logic [15:0] len, input bit cont);
    baseAddr   = b;
    length     = len;
    continuous = cont;
    if (useDut2) start2 = 1'b1; else start1 = 1'b1;
    tick();
    start1 = 1'b0;
    start2 = 1'b0;
  endtask

  task automatic clearCounts();
    xfer1 = 0; xfer2 = 0; doneCount1 = 0; doneCount2 = 0;
  endtask

  // Monitor: a transfer is a cycle with valid & ready and no abort pending.
  always @(negedge clk) begin
    if (!reset) begin
      if (valid1 && addrReady && !abort) begin
        xfer1++;
        if (q1.size() == 0) checkOutput("dut1_unexpected_xfer", {16'h0, addr1}, 32'hFFFF_FFFF);
        else checkOutput("dut1_addr", {16'h0, addr1}, {16'h0, q1.pop_front()});
      end
      if (valid2 && addrReady && !abort) begin
        xfer2++;
        if (q2.size() == 0) checkOutput("dut2_unexpected_xfer", {16'h0, addr2}, 32'hFFFF_FFFF);
        else checkOutput("dut2_addr", {16'h0, addr2}, {16'h0, q2.pop_front()});
      end
      if (done1) doneCount1++;
      if (done2) doneCount2++;
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    repeat (2) tick();
    reset = 1'b0;
    tick();
    checkOutput("reset_addr", {16'h0, addr1}, 32'h0);
    checkOutput("reset_valid", {31'h0, valid1}, 32'h0);
    checkOutput("reset_index", {16'h0, index1}, 32'h0);
    checkOutput("reset_busy", {31'h0, busy1}, 32'h0);
    checkOutput("reset_done", {31'h0, done1}, 32'h0);
    checkOutput("reset_pass", {24'h0, pass1}, 32'h0);

    $display("[TB] basic one-shot");
    clearCounts();
    addrReady = 1'b1;
    q1.push_back(16'h0010); q1.push_back(16'h0011);
    q1.push_back(16'h0012); q1.push_back(16'h0013);
    applyStimulus(1'b0, 16'h0010, 16'd4, 1'b0);
    checkOutput("basic_valid_after_start", {31'h0, valid1}, 32'h1);
    checkOutput("basic_busy_after_start", {31'h0, busy1}, 32'h1);
    repeat (6) tick();
    checkOutput("basic_done_pulses", doneCount1, 1);
    checkOutput("basic_xfers", xfer1, 4);
    checkOutput("basic_pass", {24'h0, pass1}, 32'h1);
    checkOutput("basic_index", {16'h0, index1}, 32'h3);
    checkOutput("basic_final_addr", {16'h0, addr1}, 32'h13);
    checkOutput("basic_queue_empty", q1.size(), 0);

    $display("[TB] backpressure");
    clearCounts();
    q1.push_back(16'h0010); q1.push_back(16'h0011);
    q1.push_back(16'h0012); q1.push_back(16'h0013);
    applyStimulus(1'b0, 16'h0010, 16'd4, 1'b0);
    tick();
    addrReady = 1'b0;
    repeat (3) tick();
    checkOutput("bp_hold_addr", {16'h0, addr1}, 32'h11);
    checkOutput("bp_hold_valid", {31'h0, valid1}, 32'h1);
    checkOutput("bp_xfers_while_held", xfer1, 1);
    addrReady = 1'b1;
    repeat (6) tick();
    checkOutput("bp_xfers", xfer1, 4);
    checkOutput("bp_done_pulses", doneCount1, 1);
    checkOutput("bp_pass", {24'h0, pass1}, 32'h1);
    checkOutput("bp_queue_empty", q1.size(), 0);

    $display("[TB] wrap and step");
    clearCounts();
    q2.push_back(16'hFFFC); q2.push_back(16'hFFFE);
    q2.push_back(16'h0000); q2.push_back(16'h0002);
    applyStimulus(1'b1, 16'hFFFC, 16'd4, 1'b0);
    repeat (6) tick();
    checkOutput("wrap_done_pulses", doneCount2, 1);
    checkOutput("wrap_final_addr", {16'h0, addr2}, 32'h0002);
    checkOutput("wrap_queue_empty", q2.size(), 0);
    checkOutput("wrap_dut1_idle_xfers", xfer1, 0);

    $display("[TB] continuous");
    clearCounts();
    for (int p = 0; p < 3; p++) begin
      q1.push_back(16'h0100); q1.push_back(16'h0101); q1.push_back(16'h0102);
    end
    applyStimulus(1'b0, 16'h0100, 16'd3, 1'b1);
    repeat (9) tick();
    checkOutput("cont_xfers_no_gap", xfer1, 9);
    checkOutput("cont_pass", {24'h0, pass1}, 32'h3);
    checkOutput("cont_still_busy", {31'h0, busy1}, 32'h1);
    checkOutput("cont_restart_addr", {16'h0, addr1}, 32'h0100);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    repeat (2) tick();
    checkOutput("cont_done_never", doneCount1, 0);
    checkOutput("cont_abort_valid", {31'h0, valid1}, 32'h0);
    checkOutput("cont_queue_empty", q1.size(), 0);
    continuous = 1'b0;

    $display("[TB] zero length");
    clearCounts();
    applyStimulus(1'b0, 16'h0200, 16'd0, 1'b0);
    checkOutput("zero_done_next", {31'h0, done1}, 32'h1);
    checkOutput("zero_valid", {31'h0, valid1}, 32'h0);
    checkOutput("zero_pass", {24'h0, pass1}, 32'h0);
    repeat (3) tick();
    checkOutput("zero_done_once", doneCount1, 1);
    checkOutput("zero_xfers", xfer1, 0);

    $display("[TB] start during run");
    clearCounts();
    q1.push_back(16'h0020); q1.push_back(16'h0021); q1.push_back(16'h0022);
    applyStimulus(1'b0, 16'h0020, 16'd3, 1'b0);
    baseAddr = 16'h0040;
    length   = 16'd5;
    start1   = 1'b1;
    tick();
    start1 = 1'b0;
    repeat (6) tick();
    checkOutput("rerun_xfers", xfer1, 3);
    checkOutput("rerun_done", doneCount1, 1);
    checkOutput("rerun_pass", {24'h0, pass1}, 32'h1);
    checkOutput("rerun_queue_empty", q1.size(), 0);

    $display("[TB] abort mid-run");
    clearCounts();
    q1.push_back(16'h0030); q1.push_back(16'h0031);
    applyStimulus(1'b0, 16'h0030, 16'd5, 1'b0);
    repeat (2) tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    checkOutput("abort_busy", {31'h0, busy1}, 32'h0);
    checkOutput("abort_valid", {31'h0, valid1}, 32'h0);
    repeat (3) tick();
    checkOutput("abort_index", {16'h0, index1}, 32'h2);
    checkOutput("abort_addr", {16'h0, addr1}, 32'h32);
    checkOutput("abort_no_done", doneCount1, 0);
    checkOutput("abort_xfers", xfer1, 2);
    checkOutput("abort_queue_empty", q1.size(), 0);

    $display("[TB] reset mid-run");
    clearCounts();
    q1.push_back(16'h0050); q1.push_back(16'h0051);
    applyStimulus(1'b0, 16'h0050, 16'd8, 1'b0);
    repeat (2) tick();
    reset = 1'b1;
    #1;
    checkOutput("rst_addr", {16'h0, addr1}, 32'h0);
    checkOutput("rst_valid", {31'h0, valid1}, 32'h0);
    checkOutput("rst_index", {16'h0, index1}, 32'h0);
    checkOutput("rst_busy", {31'h0, busy1}, 32'h0);
    checkOutput("rst_pass", {24'h0, pass1}, 32'h0);
    tick();
    reset = 1'b0;
    repeat (3) tick();
    checkOutput("rst_no_done", doneCount1, 0);
    checkOutput("rst_xfers", xfer1, 2);
    checkOutput("rst_queue_empty", q1.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatch);
    $finish;
  end

endmodule
